// File: rtl/mult_seq_control_pkg.sv
// mult_seq_control_pkg: state encodings and default operand width for the shift-add multiplier.
package mult_seq_control_pkg;
   localparam int DEF_WIDTH = 32;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/mult_counter.sv
// mult_counter: loadable iteration down-counter; K flags that the current decrement reaches zero.
module mult_counter
   import mult_seq_control_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Load,
   input  logic Dec,
   output logic K
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = cnt_q;
      if (Load) cnt_d = CW'(WIDTH);
      else if (Dec && cnt_q != '0) cnt_d = cnt_q - CW'(1);
   end
   always_ff @(posedge Clk) begin
      if (Reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   // Combinational so the FSM leaves ITER on the very edge that empties the counter.
   assign K = (cnt_q == CW'(1));
endmodule

// File: rtl/mult_seq_control.sv
// mult_seq_control: sequential shift-add multiplier FSM and datapath.
// Build option MULT_EARLY_EXIT_EN stops iterating once the remaining multiplier bits are zero.
module mult_seq_control
   import mult_seq_control_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [WIDTH-1:0]   Multiplicand,
   input  logic [WIDTH-1:0]   Multiplier,
   output logic               Busy,
   output logic               Done,
   output logic [2*WIDTH-1:0] Product
);
   state_e state_q, state_d;
   logic [2*WIDTH-1:0] a_q, a_d, p_q, p_d, product_q, product_d, p_next;
   logic [WIDTH-1:0] q_q, q_d;
   logic load, dec, k, finish;
   mult_counter #(.WIDTH(WIDTH)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Load  (load),
      .Dec   (dec),
      .K     (k)
   );
   assign p_next = q_q[0] ? p_q + a_q : p_q;
`ifdef MULT_EARLY_EXIT_EN
   assign finish = k | ((q_q >> 1) == '0);
`else
   assign finish = k;
`endif
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      p_d       = p_q;
      product_d = product_q;
      load      = 1'b0;
      dec       = 1'b0;
      case (state_q)
         IDLE: if (Start) begin
            a_d     = {{WIDTH{1'b0}}, Multiplicand};
            q_d     = Multiplier;
            p_d     = '0;
            load    = 1'b1;
            state_d = ITER;
         end
         ITER: begin
            dec = 1'b1;
            p_d = p_next;
            a_d = a_q << 1;
            q_d = q_q >> 1;
            if (finish) begin
               product_d = p_next;
               state_d   = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         q_q       <= '0;
         p_q       <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         q_q       <= q_d;
         p_q       <= p_d;
         product_q <= product_d;
      end
   end
   assign Busy    = (state_q == ITER) || (state_q == DONE);
   assign Done    = (state_q == DONE);
   assign Product = product_q;
endmodule

// File: tb/tb_mult_seq_control.sv
// tb_mult_seq_control: random and directed operations against an arithmetic reference model.
module tb_mult_seq_control;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [31:0] Multiplicand = '0;
   logic [31:0] Multiplier = '0;
   logic        Busy, Done;
   logic [63:0] Product;
   int checks = 0;
   int errors = 0;
   mult_seq_control #(.WIDTH(32)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Start        (Start),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Busy         (Busy),
      .Done         (Done),
      .Product      (Product)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Cycles from accept edge to the edge that raises Done.
   function automatic int exp_lat(input logic [31:0] b);
      int top = 0;
      for (int i = 0; i < 32; i++) if (b[i]) top = i + 1;
`ifdef MULT_EARLY_EXIT_EN
      return (top < 1) ? 1 : top;
`else
      return (top <= 32) ? 32 : top;
`endif
   endfunction
   // Called at a negedge with the DUT idle; hold keeps Start high and scrambles operands mid-op.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
      int n = 0;
      logic [63:0] exp = 64'(a) * 64'(b);
      Start = 1'b1;
      Multiplicand = a;
      Multiplier = b;
      @(posedge Clk);
      @(negedge Clk);
      Multiplicand = $urandom;
      Multiplier = $urandom;
      if (!hold) Start = 1'b0;
      check("busy_after_accept", 64'(Busy), 64'd1);
      while (!Done && n < 100) begin
         @(negedge Clk);
         n++;
         if (!Done) check("busy_iter", 64'(Busy), 64'd1);
      end
      check("latency", 64'(n), 64'(exp_lat(b)));
      check("product", Product, exp);
      @(negedge Clk);
      check("done_pulse", 64'(Done), 64'd0);
      check("busy_idle", 64'(Busy), 64'd0);
      check("product_hold", Product, exp);
   endtask
   initial begin
      repeat (2) @(negedge Clk);
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_product", Product, 64'd0);
      Reset = 1'b0;
      @(negedge Clk);
      run_op(32'd3, 32'd5, 1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(32'd0, 32'hDEAD_BEEF, 1'b0);
      run_op(32'h1234_5678, 32'd0, 1'b0);
      run_op(32'd7, 32'd2, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op(32'hA5A5_0001, 32'h8000_0000, 1'b0);
      run_op(32'd11, 32'd13, 1'b1);
      run_op(32'd100, 32'd9, 1'b0);
      Start = 1'b1;
      Multiplicand = 32'hCAFE_F00D;
      Multiplier = 32'h0BAD_BEEF;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      repeat (9) @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      check("midrst_busy", 64'(Busy), 64'd0);
      check("midrst_done", 64'(Done), 64'd0);
      check("midrst_product", Product, 64'd0);
      Reset = 1'b0;
      @(negedge Clk);
      run_op(32'd6, 32'd7, 1'b0);
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a = $urandom;
         logic [31:0] b = $urandom >> $urandom_range(0, 31);
         run_op(a, b, 1'($urandom_range(0, 1)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
